// File: rtl/led_blink_scheduler.sv
// Time-shares one status LED among four blink-code requesters (ON/OFF/GAP sequencing).
// Build option: define LED_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module led_blink_scheduler #(
    parameter int DIV       = 25_000_000,
    parameter int ON_TICKS  = 1,
    parameter int OFF_TICKS = 1,
    parameter int GAP_TICKS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] blink_cnt,
    output logic [3:0]  grant,
    output logic [3:0]  ack,
    output logic        busy,
    output logic        led
);
    localparam int MAX_ON_OFF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAX_TICKS  = (MAX_ON_OFF > GAP_TICKS) ? MAX_ON_OFF : GAP_TICKS;
    localparam int PSW        = $clog2(DIV);
    localparam int PW         = $clog2(MAX_TICKS + 1);

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    state_t         state_q;
    logic [PSW-1:0] presc_q;
    logic [PSW-1:0] presc_d;
    logic [PW-1:0]  phase_q;
    logic [3:0]     remaining_q;
    logic [3:0]     grant_q;
    logic [3:0]     ack_q;
    logic           busy_q;
    logic           led_q;
    logic           tick;
    logic [1:0]     pick;
    logic           found;
    logic [3:0]     pickCnt;
`ifndef LED_SCHED_FIXED_PRIO_EN
    logic [1:0]     ptr_q;
    logic [1:0]     cand;
`endif

    assign tick    = (presc_q == PSW'(DIV - 1));
    assign pickCnt = blink_cnt[{pick, 2'b00} +: 4];

    // The prescaler idles at zero, so a fresh grant always starts a full tick.
    always_comb begin
        presc_d = '0;
        if (state_q != IDLE) begin
            presc_d = tick ? '0 : presc_q + PSW'(1);
        end
    end

    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
`ifdef LED_SCHED_FIXED_PRIO_EN
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                pick  = 2'(i);
                found = 1'b1;
            end
        end
`else
        cand = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            phase_q     <= '0;
            remaining_q <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            led_q       <= 1'b0;
`ifndef LED_SCHED_FIXED_PRIO_EN
            ptr_q       <= 2'd3;
`endif
        end else begin
            presc_q <= presc_d;
            ack_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (ack_q == 4'b0 && found) begin
                        grant_q     <= 4'b0001 << pick;
                        remaining_q <= pickCnt;
                        phase_q     <= '0;
                        busy_q      <= 1'b1;
`ifndef LED_SCHED_FIXED_PRIO_EN
                        // No arbitration happens mid-service, so moving the pointer now equals moving it at ack.
                        ptr_q       <= pick;
`endif
                        if (pickCnt != 4'd0) begin
                            state_q <= ON;
                            led_q   <= 1'b1;
                        end else begin
                            state_q <= GAP;
                        end
                    end
                end
                ON: begin
                    if (tick) begin
                        if (phase_q == PW'(ON_TICKS - 1)) begin
                            phase_q     <= '0;
                            remaining_q <= remaining_q - 4'd1;
                            led_q       <= 1'b0;
                            state_q     <= (remaining_q == 4'd1) ? GAP : OFF;
                        end else begin
                            phase_q <= phase_q + PW'(1);
                        end
                    end
                end
                OFF: begin
                    if (tick) begin
                        if (phase_q == PW'(OFF_TICKS - 1)) begin
                            phase_q <= '0;
                            led_q   <= 1'b1;
                            state_q <= ON;
                        end else begin
                            phase_q <= phase_q + PW'(1);
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (phase_q == PW'(GAP_TICKS - 1)) begin
                            phase_q <= '0;
                            ack_q   <= grant_q;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            phase_q <= phase_q + PW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant = grant_q;
    assign ack   = ack_q;
    assign busy  = busy_q;
    assign led   = led_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed self-checking bench for led_blink_scheduler (DIV=4, ON=2, OFF=1, GAP=3).
// Expected grant order for the 4'b1010 case follows LED_SCHED_FIXED_PRIO_EN when defined.
module tb_led_blink_scheduler;
    localparam int DIV       = 4;
    localparam int ON_TICKS  = 2;
    localparam int OFF_TICKS = 1;
    localparam int GAP_TICKS = 3;
    localparam int ON_CYC    = DIV * ON_TICKS;
    localparam int OFF_CYC   = DIV * OFF_TICKS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0;
    logic [15:0] blinkCnt = 16'h0;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        busy;
    logic        led;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    led_blink_scheduler #(
        .DIV(DIV), .ON_TICKS(ON_TICKS), .OFF_TICKS(OFF_TICKS), .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .blink_cnt(blinkCnt),
        .grant(grant), .ack(ack), .busy(busy), .led(led)
    );

    // Single comparison point; every check in the bench is counted here.
    task automatic checkOutput(input string tag, input int got, input int exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Moves to 1 time unit past the next rising edge, where outputs are sampled and inputs driven.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] reqV, input logic [15:0] cntV);
        req      = reqV;
        blinkCnt = cntV;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        applyStimulus(4'b0, 16'h0);
        repeat (2) stepCycle();
        reset = 1'b0;
    endtask

    // Expected LED level n cycles after the grant edge for a given blink count.
    function automatic logic modelLed(input int n, input int count);
        int onSpan;
        if (count == 0) return 1'b0;
        onSpan = count * ON_CYC + (count - 1) * OFF_CYC;
        if (n >= onSpan) return 1'b0;
        return (n % (ON_CYC + OFF_CYC)) < ON_CYC;
    endfunction

    task automatic waitGrant(input string tag, input int expSteps);
        int steps;
        steps = 0;
        while (steps < 40) begin
            stepCycle();
            steps++;
            if (grant != 4'b0) break;
        end
        checkOutput({tag, "_grantLatency"}, steps, expSteps);
    endtask

    // Called one unit after a grant edge; follows the service to its ack and one cycle beyond.
    task automatic checkService(input string tag, input int idx, input int count, input int expLen,
                                input int dropAt, input int cntChangeAt, input logic [3:0] newCnt);
        int ackAt, ledErr, grantErr, busyErr;
        logic [3:0] ackSeen, grantAtAck;
        logic busyAtAck, ledAtAck;
        ackAt = -1; ledErr = 0; grantErr = 0; busyErr = 0;
        ackSeen = 4'b0; grantAtAck = 4'hf; busyAtAck = 1'b1; ledAtAck = 1'b1;
        for (int n = 0; n <= expLen + 8; n++) begin
            if (ack != 4'b0) begin
                ackAt = n; ackSeen = ack; grantAtAck = grant; busyAtAck = busy; ledAtAck = led;
                break;
            end
            if (led !== modelLed(n, count)) ledErr++;
            if (grant !== (4'b0001 << idx)) grantErr++;
            if (busy !== 1'b1) busyErr++;
            if (n == dropAt) req[idx] = 1'b0;
            if (n == cntChangeAt) blinkCnt[idx*4 +: 4] = newCnt;
            stepCycle();
        end
        checkOutput({tag, "_ackCycle"}, ackAt, expLen);
        checkOutput({tag, "_ackValue"}, ackSeen, 4'b0001 << idx);
        checkOutput({tag, "_grantAtAck"}, grantAtAck, 0);
        checkOutput({tag, "_busyAtAck"}, busyAtAck, 0);
        checkOutput({tag, "_ledAtAck"}, ledAtAck, 0);
        checkOutput({tag, "_ledErrors"}, ledErr, 0);
        checkOutput({tag, "_grantErrors"}, grantErr, 0);
        checkOutput({tag, "_busyErrors"}, busyErr, 0);
        stepCycle();
        checkOutput({tag, "_ackPulse"}, ack, 0);
        checkOutput({tag, "_noGrantInAckCycle"}, grant, 0);
    endtask

    initial begin
        int order2 [5];
        int order6 [4];
        int ackErr;
        order2 = '{0, 1, 2, 3, 0};
`ifdef LED_SCHED_FIXED_PRIO_EN
        order6 = '{1, 1, 1, 1};
`else
        order6 = '{1, 3, 1, 3};
`endif

        // Reset state
        reset = 1'b1;
        repeat (2) stepCycle();
        checkOutput("reset_led", led, 0);
        checkOutput("reset_grant", grant, 0);
        checkOutput("reset_ack", ack, 0);
        checkOutput("reset_busy", busy, 0);
        reset = 1'b0;

        // Single requester, three blinks
        applyStimulus(4'b0001, 16'h0003);
        waitGrant("t1", 1);
        checkService("t1", 0, 3, 44, -1, -1, 4'd0);
        applyStimulus(4'b0, 16'h0);

        // All four requesting: round-robin from requester 0
        applyReset();
        applyStimulus(4'b1111, 16'h1111);
        for (int s = 0; s < 5; s++) begin
            waitGrant($sformatf("t2_s%0d", s), 1);
            checkService($sformatf("t2_s%0d", s), order2[s], 1, 20, -1, -1, 4'd0);
        end
        applyStimulus(4'b0, 16'h0);

        // Zero-blink request: gap only
        applyReset();
        applyStimulus(4'b0100, 16'h0000);
        waitGrant("t3", 1);
        checkService("t3", 2, 0, 12, -1, -1, 4'd0);
        applyStimulus(4'b0, 16'h0);

        // Asynchronous reset in the middle of an ON pulse
        applyReset();
        applyStimulus(4'b0010, 16'h0050);
        waitGrant("t4", 1);
        repeat (3) stepCycle();
        checkOutput("t4_ledBeforeReset", led, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("t4_asyncLed", led, 0);
        checkOutput("t4_asyncGrant", grant, 0);
        checkOutput("t4_asyncBusy", busy, 0);
        ackErr = 0;
        for (int c = 0; c < 3; c++) begin
            stepCycle();
            if (ack !== 4'b0 || grant !== 4'b0) ackErr++;
        end
        checkOutput("t4_quietDuringReset", ackErr, 0);
        reset = 1'b0;
        waitGrant("t4b", 1);
        checkService("t4b", 1, 5, 68, -1, -1, 4'd0);
        applyStimulus(4'b0, 16'h0);

        // Request dropped and count changed mid-service
        applyReset();
        applyStimulus(4'b1000, 16'h2000);
        waitGrant("t5", 1);
        checkService("t5", 3, 2, 32, 1, 10, 4'd7);
        applyStimulus(4'b0, 16'h0);

        // Requesters 1 and 3 held together
        applyReset();
        applyStimulus(4'b1010, 16'h1111);
        for (int s = 0; s < 4; s++) begin
            waitGrant($sformatf("t6_s%0d", s), 1);
            checkService($sformatf("t6_s%0d", s), order6[s], 1, 20, -1, -1, 4'd0);
        end
        applyStimulus(4'b0, 16'h0);
        stepCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/led_blink_scheduler.md
# led_blink_scheduler

Time-shares the board's single status LED among four requesters. Each requester asks for a blink code of 0–15 blinks. The block arbitrates the requests, divides the system clock into blink ticks, and sequences ON/OFF/GAP phases. It replaces direct ownership of the LED by the free-running frequency divider in the BlinkLEDs design.

## Interface
- DIV, 25_000_000, system clock cycles per tick (≥2)
- ON_TICKS, 1, ticks LED is on per blink (≥1)
- OFF_TICKS, 1, ticks LED is off between blinks (≥1)
- GAP_TICKS, 4, ticks LED is off after the last blink, before ack (≥1)

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  4  level request per requester; hold until ack
- blink_cnt  in  16  4-bit blink count per requester; requester i uses bits [4i+3:4i]
- grant  out  4  one-hot; which requester owns the LED; 0 when idle
- ack  out  4  one-cycle pulse to the served requester
- busy  out  1  high when the FSM is not in IDLE
- led  out  1  LED drive, active-high

## Operation
Reset values: led=0, grant=0, ack=0, busy=0, state=IDLE, prescaler=0, RR pointer=3 (requester 0 has first priority).

All outputs are registered.

**Prescaler**
- Counts 0..DIV-1 and wraps while the state is not IDLE.
- Cleared to 0 on grant.
- tick = (prescaler == DIV-1).

**Phase counter**
- Counts ticks within the current phase.
- Cleared on every state change.
- Width is clog2(max(ON_TICKS, OFF_TICKS, GAP_TICKS)+1).

**FSM states**
- IDLE
  - In the cycle ack is high, no grant is made.
  - Otherwise, if req≠0: pick the winner by round-robin, searching from pointer+1 mod 4.
  - Latch the winner's blink_cnt into remaining (4 bits) and set grant.
  - remaining≠0 → ON, else → GAP.
- ON
  - led=1.
  - On the tick that completes ON_TICKS: remaining−1.
  - If the new remaining is 0 → GAP, else → OFF.
- OFF
  - led=0.
  - OFF_TICKS ticks → ON.
- GAP
  - led=0.
  - GAP_TICKS ticks → IDLE.
  - On the same edge: ack[winner]=1, grant=0, pointer=winner.

**Request and ack rules**
- blink_cnt is sampled only at grant. Later changes are ignored.
- Dropping req during service does not abort it. Service completes and ack still pulses.
- A requester whose req is still high after its ack competes normally at the next arbitration.
- Requests arriving during service wait. No request is lost while its req is held.

## Timing
- Grant latency: req seen in an IDLE cycle with ack low → grant, busy and led (if count≠0) set on the next edge.
- Service length in cycles, measured from the grant edge to the ack edge:
  - count≥1: DIV·(count·ON_TICKS + (count−1)·OFF_TICKS + GAP_TICKS)
  - count=0: DIV·GAP_TICKS
- Each ON pulse is exactly DIV·ON_TICKS cycles. Each OFF gap is exactly DIV·OFF_TICKS cycles.
- Minimum spacing between consecutive grants is 2 cycles: the ack cycle plus one IDLE cycle.
- Reset mid-operation: outputs clear immediately and asynchronously. The in-flight service is discarded and no ack is issued. After release, requests are served fresh from the full, re-sampled count, starting the search at requester 0.

## Configuration
- LED_SCHED_FIXED_PRIO_EN defined: fixed priority. The lowest-index active req always wins, and the RR pointer is not implemented. A continuously requesting low index can starve higher indices.
- Undefined (default): round-robin as described above.

## Test plan
Bench parameters: DIV=4, ON_TICKS=2, OFF_TICKS=1, GAP_TICKS=3.

1. req0=1, count 3 → ack0 44 cycles after the grant edge. led high for three 8-cycle pulses separated by 4-cycle lows, then low for 12 cycles. grant=4'b0001 throughout.
2. req=4'b1111 held continuously, all counts 1 → grant order 0,1,2,3,0. Each service is 20 cycles, with exactly 2 cycles between grants.
3. req2=1, count 0 → led stays 0, ack2 12 cycles after grant, busy high for those 12 cycles.
4. reset asserted mid-ON of a count-5 service on req1 → led, grant and busy go to 0 without waiting for a clock edge, and no ack. After release with req1 still high, 5 full blinks are delivered, then ack1.
5. req3 dropped one cycle after grant, count 2, blink_cnt changed to 7 mid-service → exactly 2 blinks, then ack3 at 32 cycles.
6. With LED_SCHED_FIXED_PRIO_EN: req=4'b1010 held → grant is always 4'b0010 and requester 3 is never granted. Without the macro, grants alternate 1,3,1,3.
